branch_resolve_unit: RTL and testbench

- Program-counter and branch-resolution stage, directly downstream of the ID-stage branch comparator. Consumes its 1-bit compare result.
- Owns the PC register and computes the next fetch address.
- Resolves taken/not-taken, flushes the wrong-path fetch, and requests a stall while branch operands are still in flight.
- Keeps saturating branch and taken-branch counters for performance debug.

---
 rtl/branch_resolve_unit_if.sv | 47 ++++
 rtl/branch_resolve_unit.sv | 101 ++++++++++
 tb/tb_branch_resolve_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Branch-resolve bus between the ID stage and the branch_resolve_unit.
//
// Signals (direction seen from the slave, i.e. the branch_resolve_unit):
//   stall_in       in   global hazard freeze from the hazard unit
//   is_branch      in   instruction in ID is a conditional branch
//   cmp_out        in   branch comparator result, 1 = condition true
//   operands_ready in   forwarded compare operands valid this cycle
//   id_pc          in   PC of the instruction in ID
//   branch_offset  in   sign-extended word offset
//   pc             out  current fetch address (registered)
//   if_flush       out  squash IF/ID at this edge (combinational)
//   stall_req      out  freeze IF/ID, bubble into EX (combinational)
//   branch_count   out  resolved branches (saturating)
//   taken_count    out  taken branches (saturating)
//   state_dbg      out  FSM state, 0 = RUN, 1 = WAIT_OPS
//
// Handshake: a branch in ID resolves on a rising edge when is_branch,
// operands_ready are 1 and stall_in is 0; while is_branch is 1 and the
// operands are not ready the unit holds stall_req high and the ID stage
// must keep the branch (and id_pc/branch_offset) stable until it resolves.
interface branch_resolve_unit_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
);
    logic             stall_in;
    logic             is_branch;
    logic             cmp_out;
    logic             operands_ready;
    logic [PC_W-1:0]  id_pc;
    logic [PC_W-1:0]  branch_offset;
    logic [PC_W-1:0]  pc;
    logic             if_flush;
    logic             stall_req;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;
    logic             state_dbg;

    modport master (
        output stall_in, is_branch, cmp_out, operands_ready, id_pc, branch_offset,
        input  pc, if_flush, stall_req, branch_count, taken_count, state_dbg
    );

    modport slave (
        input  stall_in, is_branch, cmp_out, operands_ready, id_pc, branch_offset,
        output pc, if_flush, stall_req, branch_count, taken_count, state_dbg
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Program-counter and branch-resolution stage.
//
// Owns the fetch PC, resolves conditional branches from the ID-stage
// comparator result, flushes the wrong-path fetch on a taken branch, and
// requests a pipeline stall while the branch operands are still in flight.
// Keeps saturating resolved/taken branch counters for performance debug.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    branch_resolve_unit_if.slave (see interface header for signals)
module branch_resolve_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_OPS = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic             resolve;
    logic             stall_raw;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc_inc;

    always_comb begin
        resolve = bus.is_branch & bus.operands_ready & ~bus.stall_in;
        // Offsets are relative to the instruction after the branch; the
        // sum wraps silently modulo 2^PC_W.
        target  = bus.id_pc + PC_W'(1) + bus.branch_offset;
        pc_inc  = pc_q + PC_W'(1);

        // In WAIT_OPS the request stays up until the branch actually
        // resolves; in RUN it only reflects missing operands.
        if (state_q == WAIT_OPS) begin
            stall_raw = bus.is_branch & ~resolve;
        end else begin
            stall_raw = bus.is_branch & ~bus.operands_ready;
        end

        state_d        = state_q;
        pc_d           = pc_q;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;

        // A global freeze holds PC, FSM and counters in either state.
        if (!bus.stall_in) begin
            if (bus.is_branch && bus.operands_ready) begin
                state_d = RUN;
                pc_d    = bus.cmp_out ? target : pc_inc;
                if (branch_count_q != '1) begin
                    branch_count_d = branch_count_q + CNT_W'(1);
                end
                if (bus.cmp_out && (taken_count_q != '1)) begin
                    taken_count_d = taken_count_q + CNT_W'(1);
                end
            end else if (bus.is_branch) begin
                state_d = WAIT_OPS;
            end else begin
                // Also covers a branch squashed externally while waiting.
                state_d = RUN;
                pc_d    = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= RUN;
            pc_q           <= RESET_PC;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    // Flush and stall are mutually exclusive: flush needs resolve, while
    // stall needs either missing operands (RUN) or no resolve (WAIT_OPS).
    assign bus.if_flush     = rst_n & resolve & bus.cmp_out;
    assign bus.stall_req    = rst_n & stall_raw;
    assign bus.pc           = pc_q;
    assign bus.branch_count = branch_count_q;
    assign bus.taken_count  = taken_count_q;
    assign bus.state_dbg    = (state_q == WAIT_OPS);

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    localparam int PC_W  = 16;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    branch_resolve_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(
        .PC_W     (PC_W),
        .RESET_PC (16'h0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model (spec rules, plain ints) ----------------
    int m_pc      = 0;
    int m_waiting = 0;
    int m_bc      = 0;
    int m_tc      = 0;

    logic obs_flush, obs_stall;

    // Drive one cycle, check combinational outputs before the edge and
    // registered outputs after it, all against the model.
    task automatic step(input logic r, input logic st, input logic br, input logic cmp,
                        input logic rdy, input logic [15:0] idpc, input logic [15:0] off);
        int e_flush, e_stall, n_pc, n_wait, n_bc, n_tc;
        rst_n              = r;
        bus.stall_in       = st;
        bus.is_branch      = br;
        bus.cmp_out        = cmp;
        bus.operands_ready = rdy;
        bus.id_pc          = idpc;
        bus.branch_offset  = off;
        @(negedge clk);
        e_flush = (r && br && rdy && !st && cmp) ? 1 : 0;
        if (!r || !br)        e_stall = 0;
        else if (m_waiting != 0) e_stall = (rdy && !st) ? 0 : 1;
        else                  e_stall = rdy ? 0 : 1;
        obs_flush = bus.if_flush;
        obs_stall = bus.stall_req;
        chk("if_flush", {31'd0, obs_flush}, e_flush);
        chk("stall_req", {31'd0, obs_stall}, e_stall);
        chk("flush_stall_excl", {31'd0, obs_flush & obs_stall}, 0);

        n_pc = m_pc; n_wait = m_waiting; n_bc = m_bc; n_tc = m_tc;
        if (!r) begin
            n_pc = 0; n_wait = 0; n_bc = 0; n_tc = 0;
        end else if (st) begin
            // frozen
        end else if (br && rdy) begin
            n_wait = 0;
            n_pc = cmp ? ((int'(idpc) + 1 + int'(off)) % 65536) : ((m_pc + 1) % 65536);
            if (m_bc < CNT_MAX) n_bc = m_bc + 1;
            if (cmp && m_tc < CNT_MAX) n_tc = m_tc + 1;
        end else if (br) begin
            n_wait = 1;
        end else begin
            n_wait = 0;
            n_pc = (m_pc + 1) % 65536;
        end

        @(posedge clk);
        #1;
        m_pc = n_pc; m_waiting = n_wait; m_bc = n_bc; m_tc = n_tc;
        chk("pc", {16'd0, bus.pc}, m_pc);
        chk("branch_count", {24'd0, bus.branch_count}, m_bc);
        chk("taken_count", {24'd0, bus.taken_count}, m_tc);
        chk("taken_le_branch", {31'd0, bus.taken_count <= bus.branch_count}, 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, st, br, cmp, rdy;
        logic [15:0] idpc, off;
        logic        e_flush, e_stall;
        logic [15:0] e_pc;
        logic [7:0]  e_bc, e_tc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic st, input logic br, input logic cmp,
                                input logic rdy, input logic [15:0] idpc, input logic [15:0] off,
                                input logic ef, input logic es, input logic [15:0] ep,
                                input logic [7:0] eb, input logic [7:0] et);
        vec_t v;
        v.r = r; v.st = st; v.br = br; v.cmp = cmp; v.rdy = rdy;
        v.idpc = idpc; v.off = off;
        v.e_flush = ef; v.e_stall = es; v.e_pc = ep; v.e_bc = eb; v.e_tc = et;
        return v;
    endfunction

    initial begin
        //                r  st br cmp rdy idpc      off        fl st  pc        bc  tc
        // reset held 2 edges with a resolvable taken branch present
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0));
        // release: sequential counting
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0001, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0002, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0003, 0, 0));
        // taken branch 0x10 + 1 + 4
        tbl.push_back(mk(1, 0, 1, 1, 1, 16'h0010, 16'h0004, 1, 0, 16'h0015, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0016, 1, 1));
        // not-taken with negative offset
        tbl.push_back(mk(1, 0, 1, 0, 1, 16'h0016, 16'hFFF8, 0, 0, 16'h0017, 2, 1));
        // taken with negative offset: 0x20 + 1 - 8
        tbl.push_back(mk(1, 0, 1, 1, 1, 16'h0020, 16'hFFF8, 1, 0, 16'h0019, 3, 2));
        // operand wait 3 cycles, then taken: 0x19 + 1 + 0x10
        tbl.push_back(mk(1, 0, 1, 1, 0, 16'h0019, 16'h0010, 0, 1, 16'h0019, 3, 2));
        tbl.push_back(mk(1, 0, 1, 1, 0, 16'h0019, 16'h0010, 0, 1, 16'h0019, 3, 2));
        tbl.push_back(mk(1, 0, 1, 1, 0, 16'h0019, 16'h0010, 0, 1, 16'h0019, 3, 2));
        tbl.push_back(mk(1, 0, 1, 1, 1, 16'h0019, 16'h0010, 1, 0, 16'h002A, 4, 3));
        // stall_in freezes a resolvable taken branch for 2 cycles
        tbl.push_back(mk(1, 1, 1, 1, 1, 16'h002A, 16'h0002, 0, 0, 16'h002A, 4, 3));
        tbl.push_back(mk(1, 1, 1, 1, 1, 16'h002A, 16'h0002, 0, 0, 16'h002A, 4, 3));
        tbl.push_back(mk(1, 0, 1, 1, 1, 16'h002A, 16'h0002, 1, 0, 16'h002D, 5, 4));
        // target wrap: 0xFFFE + 1 + 3 = 0x0002
        tbl.push_back(mk(1, 0, 1, 1, 1, 16'hFFFE, 16'h0003, 1, 0, 16'h0002, 6, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0003, 6, 5));
        // enter WAIT_OPS, then reset in the middle of the wait
        tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0003, 16'h0005, 0, 1, 16'h0003, 6, 5));
        tbl.push_back(mk(0, 0, 1, 0, 0, 16'h0003, 16'h0005, 0, 0, 16'h0000, 0, 0));
        // back in RUN: not-taken resolves immediately
        tbl.push_back(mk(1, 0, 1, 0, 1, 16'h0000, 16'h0005, 0, 0, 16'h0001, 1, 0));
        // wait then squash (is_branch drops): pc+1, no count
        tbl.push_back(mk(1, 0, 1, 1, 0, 16'h0001, 16'h0005, 0, 1, 16'h0001, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0001, 16'h0005, 0, 0, 16'h0002, 1, 0));
        // taken to 0xFFFF, then sequential wrap to 0x0000
        tbl.push_back(mk(1, 0, 1, 1, 1, 16'hFFF0, 16'h000E, 1, 0, 16'hFFFF, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2, 1));
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        bus.stall_in = 1'b0; bus.is_branch = 1'b0; bus.cmp_out = 1'b0;
        bus.operands_ready = 1'b0; bus.id_pc = '0; bus.branch_offset = '0;
        #0;

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].st, tbl[i].br, tbl[i].cmp, tbl[i].rdy, tbl[i].idpc, tbl[i].off);
            chk($sformatf("tbl%0d_flush", i), {31'd0, obs_flush}, {31'd0, tbl[i].e_flush});
            chk($sformatf("tbl%0d_stall", i), {31'd0, obs_stall}, {31'd0, tbl[i].e_stall});
            chk($sformatf("tbl%0d_pc", i), {16'd0, bus.pc}, {16'd0, tbl[i].e_pc});
            chk($sformatf("tbl%0d_bc", i), {24'd0, bus.branch_count}, {24'd0, tbl[i].e_bc});
            chk($sformatf("tbl%0d_tc", i), {24'd0, bus.taken_count}, {24'd0, tbl[i].e_tc});
        end

        // saturation: more taken branches than the counters can hold
        step(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            step(1, 0, 1, 1, 1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end
        chk("sat_branch_count", {24'd0, bus.branch_count}, 32'h0000_00FF);
        chk("sat_taken_count", {24'd0, bus.taken_count}, 32'h0000_00FF);
        // one not-taken after saturation must not wrap either counter
        step(1, 0, 1, 0, 1, 16'h1234, 16'h0001);
        chk("sat_hold_bc", {24'd0, bus.branch_count}, 32'h0000_00FF);

        // randomized stimulus against the model
        step(0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 1500; i++) begin
            logic r, st, br, cmp, rdy;
            r   = ($urandom_range(0, 59) != 0);
            st  = ($urandom_range(0, 4) == 0);
            br  = ($urandom_range(0, 2) != 0);
            cmp = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 2) != 0);
            step(r, st, br, cmp, rdy, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
